// File: rtl/register_pkg.sv
// ---------------------------------------------------------------------------
// register_pkg
// Shared codes for the N-bit universal shift register and its burst
// controller: operating-mode codes seen on MODO, shift direction codes on
// DIR, the burst FSM encoding and the per-cycle datapath operation select.
// ---------------------------------------------------------------------------
package register_pkg;

    // Operating modes selected by MODO while the register is idle.
    typedef enum logic [1:0] {
        MODO_SHIFT = 2'b00,
        MODO_ROT   = 2'b01,
        MODO_LOAD  = 2'b10,
        MODO_HOLD  = 2'b11
    } modo_t;

    // Shift direction: left moves bits toward the MSB, right toward the LSB.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Burst controller states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // What the datapath does to Q and S_OUT on the coming edge.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHIFT = 2'b10,
        OP_ROT   = 2'b11
    } op_t;

    // Width of a counter able to hold the value 'width' exactly.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/register_n_bits_if.sv
// ---------------------------------------------------------------------------
// register_n_bits_if
// Control and data bundle of the shift register.
//   ENB    global enable              DIR    shift direction (0 left, 1 right)
//   S_IN   serial input               MODO   idle operating mode
//   D      parallel load data         START  burst request
//   Q      register contents          S_OUT  last bit shifted/rotated out
//   BUSY   burst in progress          DONE   one-cycle burst completion pulse
//   CNT    remaining burst shifts
// The master modport belongs to whoever drives the controls; the slave
// modport is the register itself.
// ---------------------------------------------------------------------------
interface register_n_bits_if
    import register_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic             START;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] CNT;

    modport master (
        output ENB, DIR, S_IN, MODO, D, START,
        input  Q, S_OUT, BUSY, DONE, CNT
    );

    modport slave (
        input  ENB, DIR, S_IN, MODO, D, START,
        output Q, S_OUT, BUSY, DONE, CNT
    );

endinterface

// File: rtl/register_n_bits_burst_ctrl.sv
// ---------------------------------------------------------------------------
// burst_ctrl
// Sequencer of the shift register. While idle it translates MODO (or a
// START request) into a datapath operation; while bursting it issues one
// shift per enabled cycle and counts the remaining shifts down to zero,
// then pulses DONE and returns to idle.
// Ports:
//   CLK, RESET_L   clock, asynchronous active-low reset
//   enb            global enable, 0 freezes everything except DONE clearing
//   start          burst request, only honoured while idle
//   modo           idle operating mode
//   op             operation for the datapath on the coming edge
//   busy, done     burst handshake (registered)
//   cnt            remaining burst shifts (registered)
// ---------------------------------------------------------------------------
module burst_ctrl
    import register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             enb,
    input  logic             start,
    input  logic [1:0]       modo,
    output op_t              op,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // DONE is a pulse, so it defaults low every cycle, even when disabled;
    // every other piece of state defaults to holding its value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        op        = OP_HOLD;

        if (enb) begin
            case (state)
                ST_IDLE: begin
                    // A burst request outranks whatever MODO asks for.
                    if (start) begin
                        op        = OP_LOAD;
                        cnt_nxt   = CNT_FULL;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_BURST;
                    end else begin
                        case (modo)
                            MODO_SHIFT: op = OP_SHIFT;
                            MODO_ROT:   op = OP_ROT;
                            MODO_LOAD:  op = OP_LOAD;
                            default:    op = OP_HOLD;
                        endcase
                    end
                end
                ST_BURST: begin
                    op      = OP_SHIFT;
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_n_bits.sv
// ---------------------------------------------------------------------------
// register_n_bits
// WIDTH-bit universal shift register with shift, rotate, parallel load and
// hold modes, plus an autonomous burst mode that loads D and then shifts it
// out serially over WIDTH enabled cycles (parallel-to-serial conversion).
// Ports:
//   CLK       clock, all state changes on the rising edge
//   RESET_L   asynchronous active-low reset
//   bus       register_n_bits_if slave: ENB, DIR, S_IN, MODO, D, START in;
//             Q, S_OUT, BUSY, DONE, CNT out
// ---------------------------------------------------------------------------
module register_n_bits
    import register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RESET_L,
    register_n_bits_if.slave   bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    op_t              op;
    logic [WIDTH-1:0] q, q_nxt;
    logic             s_out, s_out_nxt;
    logic             departing;
    logic             fill;
    logic [WIDTH-1:0] shifted;

    burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_burst_ctrl (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .enb     (bus.ENB),
        .start   (bus.START),
        .modo    (bus.MODO),
        .op      (op),
        .busy    (bus.BUSY),
        .done    (bus.DONE),
        .cnt     (bus.CNT)
    );

    // Shift and rotate share one shifter; the only difference is whether
    // the vacated bit is filled from S_IN or from the bit that just left.
    always_comb begin
        departing = (bus.DIR == DIR_RIGHT) ? q[0] : q[WIDTH-1];
        fill      = (op == OP_ROT) ? departing : bus.S_IN;
        shifted   = (bus.DIR == DIR_RIGHT) ? {fill, q[WIDTH-1:1]}
                                           : {q[WIDTH-2:0], fill};

        q_nxt     = q;
        s_out_nxt = s_out;
        case (op)
            OP_LOAD: q_nxt = bus.D;
            OP_SHIFT,
            OP_ROT: begin
                q_nxt     = shifted;
                s_out_nxt = departing;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            q     <= '0;
            s_out <= 1'b0;
        end else begin
            q     <= q_nxt;
            s_out <= s_out_nxt;
        end
    end

    assign bus.Q     = q;
    assign bus.S_OUT = s_out;

endmodule
